// File: rtl/operand_loader_if.sv
// Operand-loader board interface: button/switch inputs and the registered
// operand/status bundle presented to the downstream ALU.
interface operand_loader_if #(
   parameter int unsigned N = 4
);
   logic         btn;
   logic [N-1:0] sw;
   logic [3:0]   sel_sw;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [3:0]   Sel;
   logic [1:0]   state;
   logic         exec_pulse;
   logic         result_valid;

   modport master (
      output btn, sw, sel_sw,
      input  A, B, Sel, state, exec_pulse, result_valid
   );

   modport slave (
      input  btn, sw, sel_sw,
      output A, B, Sel, state, exec_pulse, result_valid
   );
endinterface

// File: rtl/operand_loader.sv
// Debounced push-button sequencer loading A, B, then Sel into a registered ALU,
// with a commit strobe and a result-valid flag after the ALU latency.
module operand_loader #(
   parameter int unsigned N   = 4,
   parameter int unsigned DB  = 4,
   parameter int unsigned LAT = 2
) (
   input  logic            clk,
   input  logic            reset,
   operand_loader_if.slave bus
);
   localparam int unsigned CW = $clog2(DB);
   localparam int unsigned WW = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_SEL  = 2'b10,
      S_EXEC = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, btn_s_q;
   logic            db_q, db_d, db_dly_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    a_q, a_d, b_q, b_d;
   logic [3:0]      sel_q, sel_d;
   logic            exec_q, exec_d;
   logic            rv_q, rv_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            press;

   // Debounce: level flips only after DB consecutive disagreeing samples
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (btn_s_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DB - 1)) begin
         db_d  = ~db_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign press = db_q & ~db_dly_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      exec_d  = 1'b0;
      rv_d    = rv_q;
      wait_d  = wait_q;
      case (state_q)
         S_A: begin
            if (press) begin
               a_d     = bus.sw;
               state_d = S_B;
            end
         end
         S_B: begin
            if (press) begin
               b_d     = bus.sw;
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            if (press) begin
               sel_d   = bus.sel_sw;
               exec_d  = 1'b1;
               wait_d  = WW'(LAT);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (wait_q != '0) begin
               wait_d = wait_q - WW'(1);
               if (wait_q == WW'(1)) rv_d = 1'b1;
            end
            // presses before the result is valid are dropped, not queued
            if (press && rv_q) begin
               rv_d    = 1'b0;
               state_d = S_A;
            end
         end
         default: state_d = S_A;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         btn_s_q  <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         cnt_q    <= '0;
         state_q  <= S_A;
         a_q      <= '0;
         b_q      <= '0;
         sel_q    <= '0;
         exec_q   <= 1'b0;
         rv_q     <= 1'b0;
         wait_q   <= '0;
      end else begin
         sync1_q  <= bus.btn;
         btn_s_q  <= sync1_q;
         db_q     <= db_d;
         db_dly_q <= db_q;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sel_q    <= sel_d;
         exec_q   <= exec_d;
         rv_q     <= rv_d;
         wait_q   <= wait_d;
      end
   end

   assign bus.A            = a_q;
   assign bus.B            = b_q;
   assign bus.Sel          = sel_q;
   assign bus.state        = state_q;
   assign bus.exec_pulse   = exec_q;
   assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: two instances (LAT=2, LAT=8) share one button and
// switch set and are compared every cycle against an event-level model.
module tb_operand_loader;
   localparam int unsigned N  = 4;
   localparam int unsigned DB = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         btn;
   logic [N-1:0] sw;
   logic [3:0]   sel_sw;

   always #5 clk = ~clk;

   operand_loader_if #(.N(N)) bus2 ();
   operand_loader_if #(.N(N)) bus8 ();

   assign bus2.btn    = btn;
   assign bus2.sw     = sw;
   assign bus2.sel_sw = sel_sw;
   assign bus8.btn    = btn;
   assign bus8.sw     = sw;
   assign bus8.sel_sw = sel_sw;

   operand_loader #(.N(N), .DB(DB), .LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
   operand_loader #(.N(N), .DB(DB), .LAT(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

   int passed = 0, failed = 0, total = 0, cyc = 0;
   int lat_of [2] = '{2, 8};
   int m_st [2], m_a [2], m_b [2], m_sel [2], m_rv [2], m_exec [2], m_tc [2];
   bit lvl;
   int run;
   int press_q [$];
   int exec_cnt2 = 0, commit2 = 0, commit8 = 0, rise2 = 0, rise8 = 0;
   bit rv2_prev = 1'b0, rv8_prev = 1'b0;
   int ex0, v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_st[d] = 0; m_a[d] = 0; m_b[d] = 0; m_sel[d] = 0;
         m_rv[d] = 0; m_exec[d] = 0; m_tc[d] = -100;
      end
      lvl = 1'b0;
      run = 0;
      press_q.delete();
   endtask

   // A run of DB button samples against the settled level flips it; a rise
   // reaches the operand registers three edges after its last sample.
   task automatic model_edge();
      bit pr;
      bit rise;
      if (btn !== lvl) begin
         run++;
         if (run == DB) begin
            lvl = btn;
            run = 0;
            if (lvl) press_q.push_back(cyc + 3);
         end
      end else begin
         run = 0;
      end
      pr = 1'b0;
      if (press_q.size() > 0) begin
         if (press_q[0] == cyc) begin
            pr = 1'b1;
            void'(press_q.pop_front());
         end
      end
      for (int d = 0; d < 2; d++) begin
         rise = (m_st[d] == 3) && (m_rv[d] == 0) && (cyc == m_tc[d] + lat_of[d]);
         m_exec[d] = 0;
         if (pr) begin
            case (m_st[d])
               0: begin m_a[d] = int'(sw); m_st[d] = 1; end
               1: begin m_b[d] = int'(sw); m_st[d] = 2; end
               2: begin m_sel[d] = int'(sel_sw); m_exec[d] = 1; m_tc[d] = cyc; m_st[d] = 3; end
               default: if (m_rv[d] != 0) begin m_rv[d] = 0; m_st[d] = 0; end
            endcase
         end
         if (rise) m_rv[d] = 1;
      end
   endtask

   task automatic compare_all();
      chk("d2.A", bus2.A, m_a[0]);
      chk("d2.B", bus2.B, m_b[0]);
      chk("d2.Sel", bus2.Sel, m_sel[0]);
      chk("d2.state", bus2.state, m_st[0]);
      chk("d2.exec", bus2.exec_pulse, m_exec[0]);
      chk("d2.rv", bus2.result_valid, m_rv[0]);
      chk("d8.A", bus8.A, m_a[1]);
      chk("d8.B", bus8.B, m_b[1]);
      chk("d8.Sel", bus8.Sel, m_sel[1]);
      chk("d8.state", bus8.state, m_st[1]);
      chk("d8.exec", bus8.exec_pulse, m_exec[1]);
      chk("d8.rv", bus8.result_valid, m_rv[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (!reset) model_edge();
      #1;
      compare_all();
      if (bus2.exec_pulse) begin exec_cnt2++; commit2 = cyc; end
      if (bus8.exec_pulse) commit8 = cyc;
      if (bus2.result_valid && !rv2_prev) rise2 = cyc;
      if (bus8.result_valid && !rv8_prev) rise8 = cyc;
      rv2_prev = bus2.result_valid;
      rv8_prev = bus8.result_valid;
   endtask

   task automatic press(input int val_sw, input int val_sel);
      sw     = N'(val_sw);
      sel_sw = 4'(val_sel);
      btn    = 1'b1;
      repeat (DB + $urandom_range(0, 4)) tick();
      btn = 1'b0;
      repeat (3) tick();
      sw     = N'($urandom);
      sel_sw = 4'($urandom);
      repeat (DB + 2 + $urandom_range(0, 3)) tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".A"}, {bus2.A, bus8.A}, 0);
      chk({tag, ".B"}, {bus2.B, bus8.B}, 0);
      chk({tag, ".Sel"}, {bus2.Sel, bus8.Sel}, 0);
      chk({tag, ".state"}, {bus2.state, bus8.state}, 0);
      chk({tag, ".flags"}, {bus2.exec_pulse, bus8.exec_pulse, bus2.result_valid, bus8.result_valid}, 0);
   endtask

   initial begin
      btn = 1'b0; sw = '0; sel_sw = '0; reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      #2 reset = 1'b0;

      // glitch shorter than the debounce window
      btn = 1'b1;
      repeat (DB - 1) tick();
      btn = 1'b0;
      repeat (10) tick();
      chk("glitch.state", bus2.state, 0);
      chk("glitch.A", bus2.A, 0);

      // latency and held-button single press
      btn = 1'b1; sw = 4'd3;
      repeat (DB + 2) tick();
      chk("lat.A_before", bus2.A, 0);
      tick();
      chk("lat.A_at", bus2.A, 3);
      chk("lat.state", bus2.state, 1);
      sw = N'($urandom);
      repeat (20 - (DB + 3)) tick();
      chk("held.state", bus2.state, 1);
      chk("held.A", bus2.A, 3);
      btn = 1'b0;
      repeat (DB + 3) tick();

      press(2, $urandom);
      chk("seq.state_sel", bus2.state, 2);
      ex0 = exec_cnt2;
      press($urandom, 0);
      repeat (4) tick();
      chk("seq.A", bus2.A, 3);
      chk("seq.B", bus2.B, 2);
      chk("seq.Sel", bus2.Sel, 0);
      chk("seq.state", bus2.state, 3);
      chk("seq.exec_cnt", exec_cnt2 - ex0, 1);
      chk("seq.lat2", rise2 - commit2, 2);
      chk("seq.lat8", rise8 - commit8, 8);

      // back to S_SEL, then a press that lands exactly on the LAT=8 expiry
      press($urandom, $urandom);
      press($urandom, $urandom);
      press($urandom, $urandom);
      sel_sw = 4'd6;
      btn = 1'b1; repeat (DB) tick();
      btn = 1'b0; repeat (DB) tick();
      btn = 1'b1; repeat (DB) tick();
      btn = 1'b0; repeat (10) tick();
      chk("early.state8", bus8.state, 3);
      chk("early.rv8", bus8.result_valid, 1);
      chk("early.lat8", rise8 - commit8, 8);
      chk("early.sel8", bus8.Sel, 6);
      press($urandom, $urandom);
      chk("early.exit_state8", bus8.state, 0);
      chk("early.exit_rv8", bus8.result_valid, 0);

      // realign both instances
      #2 reset = 1'b1;
      model_reset();
      #1;
      tick();
      #2 reset = 1'b0;

      press(3, $urandom);
      press(2, $urandom);
      foreach (lat_of[i]) ;
      for (int r = 0; r < 5; r++) begin
         ex0 = exec_cnt2;
         press($urandom, 2 * r + 1);
         repeat (6) tick();
         chk("round.Sel", bus2.Sel, 2 * r + 1);
         chk("round.exec_cnt", exec_cnt2 - ex0, 1);
         press($urandom, $urandom);
         chk("round.A_hold", {bus2.A, bus8.A}, 8'h33);
         press(3, $urandom);
         chk("round.B_hold", {bus2.B, bus8.B}, 8'h22);
         press(2, $urandom);
      end

      // asynchronous reset while in S_SEL with the button held through it
      chk("mid.state", bus2.state, 2);
      btn = 1'b1;
      sw  = N'($urandom);
      repeat (3) tick();
      #2 reset = 1'b1;
      #1;
      chk_zero("async_rst");
      model_reset();
      repeat (2) tick();
      v = int'(sw);
      #2 reset = 1'b0;
      repeat (DB + 2) tick();
      chk("post_rst.state_before", bus2.state, 0);
      tick();
      chk("post_rst.A", bus2.A, v);
      chk("post_rst.state", {bus2.state, bus8.state}, 4'b0101);
      btn = 1'b0;
      repeat (10) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
